// File: rtl/register_bank_moded.sv
// -----------------------------------------------------------------------------
// register_bank_moded
//
// Bank of NUM_REG registers, each DWIDTH bits wide, whose behaviour is set
// per register by REG_MODE:
//   00 RW    : byte-enabled writes load din; reads return the feedback word.
//   01 RO    : no storage; regdata and reads follow the feedback word.
//   10 W1C   : hardware sets bits, software clears them by writing 1s;
//              a set wins over a clear in the same cycle.
//   11 PULSE : a write shows din for one cycle, then the register drops to 0.
//              Reads always return 0.
//
// Parameters
//   DWIDTH   register width in bits (multiple of 8)
//   NUM_REG  number of registers
//   ALINES   address width, 2**ALINES >= NUM_REG
//   RST_VAL  DWIDTH*NUM_REG reset image; slice i is the reset value of reg i
//   REG_MODE 2*NUM_REG mode image; slice i is the mode of reg i
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   cs         chip select; qualifies wr, rd and the decode
//   wr, rd     write / read strobes
//   addr       register address
//   din        write data
//   be         byte enables, be[k] covers din[8k+7:8k]
//   hw_set     per-register set bits (W1C registers only)
//   dfbck      per-register feedback/status data (RW and RO)
//   regdata    current contents of every register
//   decd       one-hot combinational address decode (cs && addr==i)
//   dout       registered read data, held between reads
//   dout_valid one-cycle strobe marking a read response
//   addr_err   one-cycle strobe after an out-of-range access
// -----------------------------------------------------------------------------
module register_bank_moded #(
  parameter int                        DWIDTH   = 16,
  parameter int                        NUM_REG  = 8,
  parameter int                        ALINES   = 7,
  parameter logic [DWIDTH*NUM_REG-1:0] RST_VAL  = '0,
  parameter logic [2*NUM_REG-1:0]      REG_MODE = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cs,
  input  logic                        wr,
  input  logic                        rd,
  input  logic [ALINES-1:0]           addr,
  input  logic [DWIDTH-1:0]           din,
  input  logic [DWIDTH/8-1:0]         be,
  input  logic [DWIDTH*NUM_REG-1:0]   hw_set,
  input  logic [DWIDTH*NUM_REG-1:0]   dfbck,
  output logic [DWIDTH*NUM_REG-1:0]   regdata,
  output logic [NUM_REG-1:0]          decd,
  output logic [DWIDTH-1:0]           dout,
  output logic                        dout_valid,
  output logic                        addr_err
);

  localparam int NUM_BYTES = DWIDTH / 8;

  localparam logic [1:0] MODE_RW    = 2'b00;
  localparam logic [1:0] MODE_RO    = 2'b01;
  localparam logic [1:0] MODE_W1C   = 2'b10;
  localparam logic [1:0] MODE_PULSE = 2'b11;

  // One extra bit so NUM_REG == 2**ALINES still fits in the comparison.
  localparam logic [ALINES:0] NUM_REG_A = (ALINES+1)'(NUM_REG);

  // ---------------------------------------------------------------------------
  // Access qualification
  // ---------------------------------------------------------------------------
  logic              in_range;
  logic              rd_acc;
  logic              acc_err;
  logic [DWIDTH-1:0] byte_mask;
  logic [DWIDTH-1:0] rd_data;
  logic [DWIDTH-1:0] rd_src [NUM_REG];

  assign in_range = ({1'b0, addr} < NUM_REG_A);
  // A simultaneous write and read is treated as a write only.
  assign rd_acc   = cs && rd && !wr;
  assign acc_err  = cs && (wr || rd) && !in_range;

  genvar gi;

  // Expand byte enables to a bit mask over the data word.
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : g_mask
      assign byte_mask[gi*8 +: 8] = {8{be[gi]}};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Per-register decode, storage and read source
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < NUM_REG; gi++) begin : g_reg
      localparam logic [ALINES-1:0] IDX       = ALINES'(gi);
      localparam logic [1:0]        MODE      = REG_MODE[2*gi +: 2];
      localparam logic [DWIDTH-1:0] RST_SLICE = RST_VAL[gi*DWIDTH +: DWIDTH];

      logic              we;
      logic [DWIDTH-1:0] fb_slice;
      logic [DWIDTH-1:0] set_slice;

      // decd only fires for in-range indices, so it also gates writes and
      // reads away from out-of-range addresses.
      assign decd[gi]  = cs && (addr == IDX);
      assign we        = decd[gi] && wr;
      assign fb_slice  = dfbck[gi*DWIDTH +: DWIDTH];
      assign set_slice = hw_set[gi*DWIDTH +: DWIDTH];

      if (MODE == MODE_RW) begin : g_rw
        logic [DWIDTH-1:0] value_reg;
        logic [DWIDTH-1:0] value_next;

        always_comb begin
          value_next = value_reg;
          if (we) begin
            value_next = (value_reg & ~byte_mask) | (din & byte_mask);
          end
        end

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            value_reg <= RST_SLICE;
          end else begin
            value_reg <= value_next;
          end
        end

        assign regdata[gi*DWIDTH +: DWIDTH] = value_reg;
        assign rd_src[gi]                   = fb_slice;

      end else if (MODE == MODE_RO) begin : g_ro
        // Pure status register: nothing stored, writes have no target.
        assign regdata[gi*DWIDTH +: DWIDTH] = fb_slice;
        assign rd_src[gi]                   = fb_slice;

      end else if (MODE == MODE_W1C) begin : g_w1c
        logic [DWIDTH-1:0] value_reg;
        logic [DWIDTH-1:0] value_next;
        logic [DWIDTH-1:0] clr_bits;

        assign clr_bits = we ? (din & byte_mask) : '0;

        // Clear first, then OR in the hardware sets so a set always wins.
        always_comb begin
          value_next = (value_reg & ~clr_bits) | set_slice;
        end

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            value_reg <= RST_SLICE;
          end else begin
            value_reg <= value_next;
          end
        end

        assign regdata[gi*DWIDTH +: DWIDTH] = value_reg;
        assign rd_src[gi]                   = value_reg;

      end else begin : g_pulse
        logic [DWIDTH-1:0] value_reg;
        logic [DWIDTH-1:0] value_next;

        // Without a write in this cycle the register falls back to zero;
        // consecutive writes keep it loaded and so stretch the pulse.
        always_comb begin
          value_next = '0;
          if (we) begin
            value_next = din & byte_mask;
          end
        end

        // Reset value is always zero for pulse registers, whatever RST_VAL says.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            value_reg <= '0;
          end else begin
            value_reg <= value_next;
          end
        end

        assign regdata[gi*DWIDTH +: DWIDTH] = value_reg;
        assign rd_src[gi]                   = '0;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  // decd is one-hot (or all zero when out of range), so an OR of the gated
  // sources is the selected word, and out-of-range reads naturally yield 0.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REG; i++) begin
      if (decd[i]) begin
        rd_data = rd_data | rd_src[i];
      end
    end
  end

  logic [DWIDTH-1:0] dout_reg;
  logic              dout_valid_reg;
  logic              addr_err_reg;

  // rd_data is built from pre-edge state, so an hw_set arriving in the read
  // cycle shows up in the register but not in this response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      addr_err_reg   <= 1'b0;
    end else begin
      dout_valid_reg <= rd_acc;
      addr_err_reg   <= acc_err;
      if (rd_acc) begin
        dout_reg <= rd_data;
      end
    end
  end

  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign addr_err   = addr_err_reg;

  // Inputs whose bits are only consumed by some register modes; folding them
  // here gives every bit a load whatever REG_MODE selects.
  logic unused_inputs;
  assign unused_inputs = ^{hw_set, dfbck, din, be};

endmodule

// File: doc/register_bank_moded.md
REGISTER_BANK_MODED -- requirements
Module: register_bank_moded

Interface
REQ-001 SHALL provide parameter DWIDTH, default 16, register width in bits; a multiple of 8.
REQ-002 SHALL provide parameter NUM_REG, default 8, number of registers.
REQ-003 SHALL provide parameter ALINES, default 7, address width; 2**ALINES >= NUM_REG.
REQ-004 SHALL provide parameter RST_VAL, default all-zero, DWIDTH*NUM_REG bits; slice i is the reset value of register i.
REQ-005 SHALL provide parameter REG_MODE, default all-zero, 2*NUM_REG bits; slice i encodes 00=RW, 01=RO, 10=W1C, 11=PULSE.
REQ-006 clk  input  1  single clock, rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 cs  input  1  chip select.
REQ-009 wr  input  1  write strobe, qualified by cs.
REQ-010 rd  input  1  read strobe, qualified by cs.
REQ-011 addr  input  ALINES  register address.
REQ-012 din  input  DWIDTH  write data.
REQ-013 be  input  DWIDTH/8  byte enables; be[k] covers din[8k+7:8k].
REQ-014 hw_set  input  DWIDTH*NUM_REG  hardware set bits for W1C registers; ignored for other modes.
REQ-015 dfbck  input  DWIDTH*NUM_REG  feedback/status data for RW and RO reads.
REQ-016 regdata  output  DWIDTH*NUM_REG  current register contents.
REQ-017 decd  output  NUM_REG  one-hot address decode.
REQ-018 dout  output  DWIDTH  registered read data.
REQ-019 dout_valid  output  1  one-cycle read-data strobe.
REQ-020 addr_err  output  1  one-cycle out-of-range access strobe.

Function
REQ-021 decd[i] SHALL be combinational: cs && addr==i.
REQ-022 A write SHALL occur at a clk edge when cs && wr && addr<NUM_REG; only bytes with be[k]=1 are affected.
REQ-023 RW: enabled bytes SHALL load din; regdata slice = stored value.
REQ-024 RO: writes SHALL be ignored; no storage; regdata slice SHALL equal the dfbck slice.
REQ-025 W1C: each bit SHALL clear when written with 1 in an enabled byte, and SHALL set when its hw_set bit is 1; set SHALL win over clear in the same cycle.
REQ-026 PULSE: enabled bytes SHALL load din for exactly one cycle and return to 0 on the next edge unless rewritten; back-to-back writes SHALL extend the pulse.
REQ-027 A read SHALL be accepted when cs && rd && !wr; the response SHALL appear on the next edge with dout_valid=1 for one cycle.
REQ-028 Read source: RW and RO return the dfbck slice; W1C returns the stored value; PULSE returns 0.
REQ-029 Read data SHALL be sampled from pre-edge values (an hw_set in the read cycle is not visible in that read).
REQ-030 cs && wr && rd together SHALL perform the write only; dout_valid SHALL stay 0.
REQ-031 addr>=NUM_REG with cs && (wr||rd): no register SHALL change, and addr_err SHALL pulse 1 on the next edge; a read SHALL also return dout=0 with dout_valid=1.
REQ-032 dout SHALL hold its last value while dout_valid=0.
REQ-033 Back-to-back reads SHALL be supported at one per cycle with no bubbles.

Reset
REQ-034 On rst: RW and W1C registers = RST_VAL slice, PULSE registers = 0 regardless of RST_VAL, dout=0, dout_valid=0, addr_err=0.
REQ-035 rst asserted mid-read SHALL discard the pending response; no dout_valid after rst deasserts.

Verification
REQ-036 RW, reg 2, RST_VAL slice 0x1234: write din=0xABCD be=01 -> regdata slice 0x12CD; read with dfbck slice 0x5555 -> next cycle dout=0x5555, dout_valid=1.
REQ-037 W1C, reg 3: hw_set=0x0081 -> value 0x0081; write din=0x0001 be=11 with hw_set bit0=1 in the same cycle -> value stays 0x0081; next write 0x0001 -> 0x0080.
REQ-038 PULSE, reg 4: write 0x0003 -> regdata slice 0x0003 for one cycle then 0x0000; read -> dout=0x0000.
REQ-039 addr=9 with NUM_REG=8: read -> dout=0, dout_valid=1, addr_err=1 for one cycle; write -> no regdata change, addr_err=1.
REQ-040 cs=wr=rd=1 to RW reg 0 -> register written, dout_valid=0; rst pulsed the cycle after a read -> dout=0, dout_valid=0.
